// File: rtl/ecc_pkg.sv
// Shared definitions for the Jacobian point-doubling datapath: default width,
// doubling FSM states and the projective encoding returned for the point at infinity.
package ecc_pkg;

  localparam int unsigned ECC_WIDTH = 256;

  // Infinity is reported as (1, 1, 0)
  localparam int unsigned INF_X = 1;
  localparam int unsigned INF_Y = 1;
  localparam int unsigned INF_Z = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_Y2,
    ST_S,
    ST_X2,
    ST_Z2,
    ST_Z4,
    ST_AZ4,
    ST_MADD,
    ST_M2,
    ST_TSUB,
    ST_Y4,
    ST_MSX,
    ST_YZ,
    ST_DONE
  } dbl_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Serial interleaved modular multiplier, MSB-first shift-add with per-step reduction.
// done pulses WIDTH+2 cycles after start, counting the start cycle as the first.
module mod_mul_serial
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = ECC_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rp;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;

  // One step: acc = 2*acc mod p, then conditionally add a mod p
  always_comb begin
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, rp}) dbl = dbl - {1'b0, rp};
    sum = {1'b0, dbl[WIDTH-1:0]};
    if (rb[WIDTH-1]) sum = sum + {1'b0, ra};
    if (sum >= {1'b0, rp}) sum = sum - {1'b0, rp};
    acc_next = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      acc  <= '0;
      ra   <= '0;
      rb   <= '0;
      rp   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc  <= '0;
        ra   <= a;
        rb   <= b;
        rp   <= p;
        cnt  <= CW'(WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= acc_next;
        rb  <= {rb[WIDTH-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/jacob_double.sv
// Jacobian point doubling over GF(p) using one shared serial modular multiplier.
// Optional A_ZERO_SKIP_EN: skip the a*Z1^4 multiplies when the sampled a is zero.
module jacob_double
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = ECC_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] z1,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] z3,
  output logic             flag
);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    return (x >= y) ? (x - y) : (x - y + m);
  endfunction

  function automatic logic [WIDTH-1:0] mod_dbl(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] m);
    return mod_add(x, x, m);
  endfunction

  dbl_state_e       state;
  logic [WIDTH-1:0] rx, ry, rz, ra, rp;
  logic             inf;
  logic [WIDTH-1:0] y2, s, m, zt, x3r, tt, y8, y3r;
  logic [WIDTH-1:0] op_a, op_b;
  logic             mul_start;
  logic [WIDTH-1:0] prod;
  logic             mul_done;
  logic [WIDTH-1:0] m_sum;
  logic             skip_az;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .nrst   (nrst),
    .start  (mul_start),
    .a      (op_a),
    .b      (op_b),
    .p      (rp),
    .result (prod),
    .done   (mul_done)
  );

  assign m_sum = mod_add(m, zt, rp);

`ifdef A_ZERO_SKIP_EN
  assign skip_az = (ra == '0);
`else
  assign skip_az = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= ST_IDLE;
      rx        <= '0;
      ry        <= '0;
      rz        <= '0;
      ra        <= '0;
      rp        <= '0;
      inf       <= 1'b0;
      y2        <= '0;
      s         <= '0;
      m         <= '0;
      zt        <= '0;
      x3r       <= '0;
      tt        <= '0;
      y8        <= '0;
      y3r       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mul_start <= 1'b0;
      x3        <= '0;
      y3        <= '0;
      z3        <= '0;
      flag      <= 1'b0;
    end else begin
      flag      <= 1'b0;
      mul_start <= 1'b0;
      unique case (state)
        ST_IDLE: if (en) begin
          rx    <= x1;
          ry    <= y1;
          rz    <= z1;
          ra    <= a;
          rp    <= p;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          inf       <= (ry == '0) || (rz == '0);
          op_a      <= ry;
          op_b      <= ry;
          mul_start <= 1'b1;
          state     <= ST_Y2;
        end
        ST_Y2: if (mul_done) begin
          y2        <= prod;
          op_a      <= rx;
          op_b      <= prod;
          mul_start <= 1'b1;
          state     <= ST_S;
        end
        ST_S: if (mul_done) begin
          s         <= mod_dbl(mod_dbl(prod, rp), rp);
          op_a      <= rx;
          op_b      <= rx;
          mul_start <= 1'b1;
          state     <= ST_X2;
        end
        // m holds 3*X1^2 until the a*Z1^4 term is folded in
        ST_X2: if (mul_done) begin
          m <= mod_add(mod_dbl(prod, rp), prod, rp);
          if (skip_az) begin
            zt    <= '0;
            state <= ST_MADD;
          end else begin
            op_a      <= rz;
            op_b      <= rz;
            mul_start <= 1'b1;
            state     <= ST_Z2;
          end
        end
        ST_Z2: if (mul_done) begin
          op_a      <= prod;
          op_b      <= prod;
          mul_start <= 1'b1;
          state     <= ST_Z4;
        end
        ST_Z4: if (mul_done) begin
          op_a      <= ra;
          op_b      <= prod;
          mul_start <= 1'b1;
          state     <= ST_AZ4;
        end
        ST_AZ4: if (mul_done) begin
          zt    <= prod;
          state <= ST_MADD;
        end
        ST_MADD: begin
          m         <= m_sum;
          op_a      <= m_sum;
          op_b      <= m_sum;
          mul_start <= 1'b1;
          state     <= ST_M2;
        end
        ST_M2: if (mul_done) begin
          x3r   <= mod_sub(prod, mod_dbl(s, rp), rp);
          state <= ST_TSUB;
        end
        ST_TSUB: begin
          tt        <= mod_sub(s, x3r, rp);
          op_a      <= y2;
          op_b      <= y2;
          mul_start <= 1'b1;
          state     <= ST_Y4;
        end
        ST_Y4: if (mul_done) begin
          y8        <= mod_dbl(mod_dbl(mod_dbl(prod, rp), rp), rp);
          op_a      <= m;
          op_b      <= tt;
          mul_start <= 1'b1;
          state     <= ST_MSX;
        end
        ST_MSX: if (mul_done) begin
          y3r       <= mod_sub(prod, y8, rp);
          op_a      <= ry;
          op_b      <= rz;
          mul_start <= 1'b1;
          state     <= ST_YZ;
        end
        ST_YZ: if (mul_done) begin
          if (inf) begin
            x3 <= WIDTH'(INF_X);
            y3 <= WIDTH'(INF_Y);
            z3 <= WIDTH'(INF_Z);
          end else begin
            x3 <= x3r;
            y3 <= y3r;
            z3 <= mod_dbl(prod, rp);
          end
          flag  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacob_double.sv
// Self-checking bench for jacob_double: directed small-field cases plus randomized
// P-256 doublings compared in affine form against a field-arithmetic reference.
module tb_jacob_double;

  localparam int W       = 256;
  localparam int LAT_MAX = 11 * (W + 4);

  typedef logic [W-1:0]   num_t;
  typedef logic [2*W-1:0] wide_t;

  localparam num_t P256 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam num_t A256 = P256 - 256'd3;
  localparam num_t GX   = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
  localparam num_t GY   = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;

  logic clk = 1'b0;
  logic nrst, en, flag;
  num_t p, x1, y1, z1, a, x3, y3, z3;

  int n_tests = 0;
  int n_fail  = 0;
  int flag_cnt = 0;

  jacob_double dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .p    (p),
    .x1   (x1),
    .y1   (y1),
    .z1   (z1),
    .a    (a),
    .x3   (x3),
    .y3   (y3),
    .z3   (z3),
    .flag (flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (flag === 1'b1) flag_cnt++;

  task automatic chk(input string tag, input num_t got, input num_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Field reference model
  function automatic num_t fmul(input num_t x, input num_t y, input num_t md);
    wide_t t;
    t = wide_t'(x) * wide_t'(y);
    return num_t'(t % wide_t'(md));
  endfunction

  function automatic num_t fadd(input num_t x, input num_t y, input num_t md);
    return num_t'((wide_t'(x) + wide_t'(y)) % wide_t'(md));
  endfunction

  function automatic num_t fsub(input num_t x, input num_t y, input num_t md);
    return fadd(x, md - (y % md), md);
  endfunction

  function automatic num_t finv(input num_t x, input num_t md);
    num_t r = num_t'(1);
    num_t b = x % md;
    num_t e = md - num_t'(2);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = fmul(r, b, md);
      b = fmul(b, b, md);
    end
    return r;
  endfunction

  task automatic affine_dbl(input num_t x, input num_t y, input num_t ca, input num_t md,
                            output num_t xr, output num_t yr);
    num_t lam;
    lam = fmul(fadd(fmul(num_t'(3), fmul(x, x, md), md), ca, md), finv(fadd(y, y, md), md), md);
    xr  = fsub(fmul(lam, lam, md), fadd(x, x, md), md);
    yr  = fsub(fmul(lam, fsub(x, xr, md), md), y, md);
  endtask

  task automatic to_affine(input num_t jx, input num_t jy, input num_t jz, input num_t md,
                           output num_t ax, output num_t ay);
    num_t zi, zi2;
    zi  = finv(jz, md);
    zi2 = fmul(zi, zi, md);
    ax  = fmul(jx, zi2, md);
    ay  = fmul(jy, fmul(zi2, zi, md), md);
  endtask

  function automatic num_t rnd();
    num_t r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], $urandom()};
    return r;
  endfunction

  task automatic start_op(input num_t px, input num_t py, input num_t pz, input num_t pp, input num_t pa);
    x1 = px; y1 = py; z1 = pz; p = pp; a = pa; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input int lat0, output int lat);
    lat = lat0;
    while (flag !== 1'b1 && lat < LAT_MAX + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_flag"}, num_t'(flag), num_t'(1));
    chk({tag, "_lat_bound"}, num_t'(lat <= LAT_MAX), num_t'(1));
  endtask

  task automatic finish_op(input string tag, input int fc0, input int nflags);
    @(posedge clk); #1;
    chk({tag, "_flag_low"}, num_t'(flag), num_t'(0));
    chk({tag, "_flag_count"}, num_t'(flag_cnt - fc0), num_t'(nflags));
  endtask

  task automatic chk_out(input string tag, input num_t ex, input num_t ey, input num_t ez);
    chk({tag, "_x3"}, x3, ex);
    chk({tag, "_y3"}, y3, ey);
    chk({tag, "_z3"}, z3, ez);
  endtask

  initial begin
    int   lat, lat_ref, fc0, exp_lat;
    num_t px, py, zz, jx, jy, ex, ey, ax, ay;

    nrst = 1'b1; en = 1'b0;
    p = '0; x1 = '0; y1 = '0; z1 = '0; a = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", '0, '0, '0);
    chk("reset_flag", num_t'(flag), num_t'(0));
    nrst = 1'b0;
    @(posedge clk); #1;

    // Small curve: 2*(2,6) on p=29, a=4
    fc0 = flag_cnt;
    start_op(num_t'(2), num_t'(6), num_t'(1), num_t'(29), num_t'(4));
    wait_flag("basic", 0, lat);
    lat_ref = lat;
    chk_out("basic", num_t'(28), num_t'(27), num_t'(12));
    finish_op("basic", fc0, 1);

    // Reset mid-computation aborts without a flag
    fc0 = flag_cnt;
    start_op(num_t'(2), num_t'(6), num_t'(1), num_t'(29), num_t'(4));
    repeat (200) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_out("abort", '0, '0, '0);
    chk("abort_flag", num_t'(flag), num_t'(0));
    nrst = 1'b0;
    repeat (LAT_MAX + 10) @(posedge clk);
    #1;
    chk("abort_no_flag", num_t'(flag_cnt - fc0), num_t'(0));
    chk_out("abort_hold", '0, '0, '0);

    fc0 = flag_cnt;
    start_op(num_t'(2), num_t'(6), num_t'(1), num_t'(29), num_t'(4));
    wait_flag("rerun", 0, lat);
    chk("rerun_lat", num_t'(lat), num_t'(lat_ref));
    chk_out("rerun", num_t'(28), num_t'(27), num_t'(12));
    finish_op("rerun", fc0, 1);

    // Point at infinity inputs
    fc0 = flag_cnt;
    start_op(num_t'(2), num_t'(0), num_t'(1), num_t'(29), num_t'(4));
    wait_flag("inf_y", 0, lat);
    chk("inf_y_lat", num_t'(lat), num_t'(lat_ref));
    chk_out("inf_y", num_t'(1), num_t'(1), num_t'(0));
    finish_op("inf_y", fc0, 1);

    start_op(num_t'(2), num_t'(6), num_t'(1), num_t'(29), num_t'(4));
    wait_flag("pre_inf_z", 0, lat);
    finish_op("pre_inf_z", fc0 + 1, 1);
    fc0 = flag_cnt;
    start_op(num_t'(5), num_t'(7), num_t'(0), num_t'(29), num_t'(4));
    wait_flag("inf_z", 0, lat);
    chk("inf_z_lat", num_t'(lat), num_t'(lat_ref));
    chk_out("inf_z", num_t'(1), num_t'(1), num_t'(0));
    finish_op("inf_z", fc0, 1);

    // en held while busy, inputs disturbed after sampling
    fc0 = flag_cnt;
    x1 = num_t'(2); y1 = num_t'(6); z1 = num_t'(1); p = num_t'(29); a = num_t'(4); en = 1'b1;
    @(posedge clk); #1;
    x1 = num_t'(17); y1 = num_t'(3); z1 = num_t'(9); a = num_t'(11);
    repeat (4) @(posedge clk);
    #1;
    en = 1'b0;
    chk_out("busy_hold", num_t'(1), num_t'(1), num_t'(0));
    wait_flag("busy", 4, lat);
    chk("busy_lat", num_t'(lat), num_t'(lat_ref));
    chk_out("busy", num_t'(28), num_t'(27), num_t'(12));
    // en during the DONE cycle is ignored, then taken from IDLE
    x1 = num_t'(2); y1 = num_t'(0); z1 = num_t'(1); en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    chk_out("done_en_hold", num_t'(28), num_t'(27), num_t'(12));
    wait_flag("done_en", 0, lat);
    chk("done_en_lat", num_t'(lat), num_t'(lat_ref));
    chk_out("done_en", num_t'(1), num_t'(1), num_t'(0));
    finish_op("done_en", fc0, 2);

    // Randomized P-256 doublings along a chain of points
    px = GX; py = GY;
    for (int i = 0; i < 5; i++) begin
      zz = rnd() % P256;
      if (zz == '0) zz = num_t'(1);
      jx = fmul(px, fmul(zz, zz, P256), P256);
      jy = fmul(py, fmul(fmul(zz, zz, P256), zz, P256), P256);
      affine_dbl(px, py, A256, P256, ex, ey);
      fc0 = flag_cnt;
      start_op(jx, jy, zz, P256, A256);
      wait_flag("p256", 0, lat);
      chk("p256_lat", num_t'(lat), num_t'(lat_ref));
      to_affine(x3, y3, z3, P256, ax, ay);
      chk("p256_x", ax, ex);
      chk("p256_y", ay, ey);
      finish_op("p256", fc0, 1);
      px = ex; py = ey;
    end

    // a = 0 curve over the P-256 field
    px = rnd() % P256;
    py = rnd() % P256;
    if (py == '0) py = num_t'(1);
    zz = rnd() % P256;
    if (zz == '0) zz = num_t'(1);
    jx = fmul(px, fmul(zz, zz, P256), P256);
    jy = fmul(py, fmul(fmul(zz, zz, P256), zz, P256), P256);
    affine_dbl(px, py, '0, P256, ex, ey);
`ifdef A_ZERO_SKIP_EN
    exp_lat = lat_ref - 3 * (W + 2);
`else
    exp_lat = lat_ref;
`endif
    fc0 = flag_cnt;
    start_op(jx, jy, zz, P256, '0);
    wait_flag("azero", 0, lat);
    chk("azero_lat", num_t'(lat), num_t'(exp_lat));
    to_affine(x3, y3, z3, P256, ax, ay);
    chk("azero_x", ax, ex);
    chk("azero_y", ay, ey);
    finish_op("azero", fc0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jacob_double.md
Name: jacob_double

Overview:
- Sequential point-doubling unit for short-Weierstrass elliptic curves y^2 = x^3 + a*x + b over a prime field GF(p), in Jacobian coordinates.
- Takes (X1,Y1,Z1), p and a; returns (X3,Y3,Z3) = 2*(X1,Y1,Z1).
- Leaf arithmetic block used by the scalar-multiplication controller; one start pulse in, one done pulse out.

Parameters:
- WIDTH, 256, bit width of p, a and all coordinates.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  reset; synchronous and active-high (asserted = 1), despite the name.
- en  input  1  start pulse; inputs are sampled on the cycle en=1 while idle.
- p  input  WIDTH  odd prime modulus, p > 3.
- x1  input  WIDTH  X1 coordinate, < p.
- y1  input  WIDTH  Y1 coordinate, < p.
- z1  input  WIDTH  Z1 coordinate, < p.
- a  input  WIDTH  curve coefficient a, < p. Narrower drivers are zero-extended.
- x3  output  WIDTH  result X3.
- y3  output  WIDTH  result Y3.
- z3  output  WIDTH  result Z3.
- flag  output  1  done; one-cycle pulse when x3/y3/z3 become valid.

Behaviour:
- Reset (nrst=1 at a clock edge):
  - x3, y3, z3 and flag are cleared to 0.
  - FSM returns to IDLE.
  - Reset mid-operation aborts the computation and no flag is emitted.
- Formulas, all mod p:
  - S = 4*X1*Y1^2
  - M = 3*X1^2 + a*Z1^4
  - X3 = M^2 - 2*S
  - Y3 = M*(S - X3) - 8*Y1^4
  - Z3 = 2*Y1*Z1
- Arithmetic rules:
  - Add, subtract and double are single-cycle conditional-correct operations: add/sub, then subtract or add p once.
  - Multiplication uses one shared serial interleaved modular multiplier: MSB-first shift-add, each step reduced below p.
  - The multiplier takes WIDTH+2 cycles per product.
  - All intermediates stay in [0, p-1].
- FSM states: IDLE, LOAD, then one state per multiply (Y2, S, X2, Z2, Z4, AZ4, M2, Y4, MSX, YZ), interleaved with add/sub steps, then DONE.
  - IDLE --en--> LOAD.
  - DONE lasts one cycle: x3/y3/z3 are registered, flag=1, then back to IDLE.
- Latency:
  - Fixed for a given WIDTH and config, independent of operand values.
  - Flag rises no later than 11*(WIDTH+4) cycles after the en cycle.
- Handshake:
  - en while busy is ignored.
  - Input changes after the sampling cycle have no effect.
  - x3/y3/z3 hold their last result until the next DONE or reset.
  - en asserted in the same cycle as DONE is ignored; the unit accepts it from IDLE next cycle.
- Point at infinity: if sampled z1==0 or y1==0, the result is x3=1, y3=1, z3=0, still reported through the normal fixed-latency flag pulse.
- Out-of-range inputs (>= p): result undefined, no hang; flag still pulses.

Optional Feature:
- Macro A_ZERO_SKIP_EN.
- When defined and the sampled a == 0, the Z2/Z4/AZ4 multiplies are skipped and M = 3*X1^2. Latency shrinks by 3*(WIDTH+2) cycles for that operation.
- When not defined, all ten multiplies always run.
- Results are bit-identical either way.

Decomposition:
- Shared package ecc_pkg holds:
  - the WIDTH default constant;
  - the FSM state enum;
  - the infinity encoding constants (1,1,0).
- One sub-module, mod_mul_serial: ports clk, nrst, start, a, b, p, result, done; latency WIDTH+2.
- Add/sub/double stay as inline functions in jacob_double.

Test Plan:
- p=29, x1=2, y1=6, z1=1, a=4, en pulse one cycle after reset release -> single flag pulse with x3=28, y3=27, z3=12 (affine (1,5), which equals 2*(2,6) on b=20).
- Same operands, then nrst=1 asserted mid-computation -> outputs 0, no flag; a re-run after release gives 28/27/12.
- p=29, x1=2, y1=0, z1=1, a=4 -> x3=1, y3=1, z3=0; z1=0 with any x1/y1 -> same result.
- en held high for several cycles / pulsed again while busy -> exactly one flag per accepted start; outputs unchanged until flag.
- Randomized 256-bit P-256 points (a=p-3) -> after conversion to affine, results match a software model; flag at constant latency.
- a=0 curve, with and without A_ZERO_SKIP_EN -> identical x3/y3/z3; latency difference equals 3*(WIDTH+2).
